// File: rtl/sram_axi_slave_pkg.sv
// sram_axi_slave_pkg: AXI widths, burst/response codes and the strobe-to-bit-mask helper.
package sram_axi_slave_pkg;
  localparam int ID_BITS = 8;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int LEN_BITS = 4;
  localparam int MEM_AW = 14;
  localparam int STRB_BITS = DATA_BITS / 8;
  localparam logic [2:0] SIZE_4B = 3'b010;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;
  function automatic logic [DATA_BITS-1:0] strb_to_bweb(input logic [STRB_BITS-1:0] strb);
    for (int i = 0; i < STRB_BITS; i++) strb_to_bweb[8*i +: 8] = {8{~strb[i]}};
  endfunction
endpackage

// File: rtl/sram_axi_slave_if.sv
// sram_axi_slave_if: AXI4 read/write channels between the interconnect master and the SRAM slave.
interface sram_axi_slave_if;
  import sram_axi_slave_pkg::*;
  logic [ID_BITS-1:0]   arid;
  logic [ADDR_BITS-1:0] araddr;
  logic [LEN_BITS-1:0]  arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;
  logic [ID_BITS-1:0]   rid;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;
  logic [ID_BITS-1:0]   awid;
  logic [ADDR_BITS-1:0] awaddr;
  logic [LEN_BITS-1:0]  awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;
  logic [ID_BITS-1:0]   bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/sram_axi_slave_burst_addr_gen.sv
// axi_burst_addr_gen: tracks word address, beat count and last-beat flag of one AXI burst.
module axi_burst_addr_gen
  import sram_axi_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [LEN_BITS-1:0] len_i,
  input  logic [1:0]        burst_i,
  input  logic              adv_i,
  output logic [MEM_AW-1:0] addr_o,
  output logic              last_o
);
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [LEN_BITS-1:0] len_q, len_d, beat_q, beat_d;
  logic                fixed_q, fixed_d;
  // WRAP bursts step like INCR; the word address wraps naturally at the SRAM size
  always_comb begin
    addr_d  = load_i ? addr_i : ((adv_i && !fixed_q) ? addr_q + MEM_AW'(1) : addr_q);
    len_d   = load_i ? len_i : len_q;
    fixed_d = load_i ? (burst_i == BURST_FIXED) : fixed_q;
    beat_d  = load_i ? '0 : (adv_i ? beat_q + LEN_BITS'(1) : beat_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      fixed_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      fixed_q <= fixed_d;
    end
  end
  assign addr_o = addr_q;
  assign last_o = beat_q == len_q;
endmodule

// File: rtl/sram_axi_slave.sv
// sram_axi_slave: AXI4 slave with one outstanding INCR/FIXED burst, mapped onto a single-port
// SRAM with 1-cycle read latency (2 cycles per read beat, 1 cycle per write beat).
module sram_axi_slave
  import sram_axi_slave_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  sram_axi_slave_if.slave      axi,
  output logic                 sram_ceb_o,
  output logic                 sram_web_o,
  output logic [DATA_BITS-1:0] sram_bweb_o,
  output logic [MEM_AW-1:0]    sram_a_o,
  output logic [DATA_BITS-1:0] sram_di_o,
  input  logic [DATA_BITS-1:0] sram_do_i
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_e;
  state_e               state_q, state_d;
  logic                 rst_done_q;
  logic                 fresh_q;
  logic                 err_q, err_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [DATA_BITS-1:0] rdata_q, rdata;
  logic                 aw_rdy, ar_rdy, aw_hs, ar_hs, adv, last;
  logic [MEM_AW-1:0]    mem_addr;
  logic                 unused;
  assign aw_rdy = (state_q == IDLE) & rst_done_q;
  assign ar_rdy = aw_rdy & ~axi.awvalid;
  assign aw_hs  = aw_rdy & axi.awvalid;
  assign ar_hs  = ar_rdy & axi.arvalid;
  // sram_do is only valid in the first RD_DATA cycle, so it is passed through then and held after
  assign rdata  = fresh_q ? sram_do_i : rdata_q;
  assign unused = ^{axi.arsize, axi.awsize, axi.araddr[ADDR_BITS-1:MEM_AW+2], axi.araddr[1:0],
                    axi.awaddr[ADDR_BITS-1:MEM_AW+2], axi.awaddr[1:0]};
  axi_burst_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (aw_hs | ar_hs),
    .addr_i  (aw_hs ? axi.awaddr[MEM_AW+1:2] : axi.araddr[MEM_AW+1:2]),
    .len_i   (aw_hs ? axi.awlen : axi.arlen),
    .burst_i (aw_hs ? axi.awburst : axi.arburst),
    .adv_i   (adv),
    .addr_o  (mem_addr),
    .last_o  (last)
  );
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    err_d       = err_q;
    adv         = 1'b0;
    sram_ceb_o  = 1'b1;
    sram_web_o  = 1'b1;
    sram_bweb_o = '1;
    sram_di_o   = '0;
    case (state_q)
      IDLE: begin
        id_d    = aw_hs ? axi.awid : (ar_hs ? axi.arid : id_q);
        err_d   = (aw_hs | ar_hs) ? 1'b0 : err_q;
        state_d = aw_hs ? WR_DATA : (ar_hs ? RD_REQ : IDLE);
      end
      RD_REQ: begin
        sram_ceb_o = 1'b0;
        state_d    = RD_DATA;
      end
      RD_DATA: begin
        adv     = axi.rready & ~last;
        state_d = axi.rready ? (last ? IDLE : RD_REQ) : RD_DATA;
      end
      WR_DATA: begin
        // termination follows the latched length; a disagreeing WLAST only flags SLVERR
        if (axi.wvalid) begin
          sram_ceb_o  = 1'b0;
          sram_web_o  = 1'b0;
          sram_bweb_o = strb_to_bweb(axi.wstrb);
          sram_di_o   = axi.wdata;
          adv         = 1'b1;
          err_d       = err_q | (axi.wlast != last);
          state_d     = last ? WR_RESP : WR_DATA;
        end
      end
      WR_RESP: state_d = axi.bready ? IDLE : WR_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rst_done_q <= 1'b0;
      fresh_q    <= 1'b0;
      err_q      <= 1'b0;
      id_q       <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      fresh_q    <= state_q == RD_REQ;
      err_q      <= err_d;
      id_q       <= id_d;
      rdata_q    <= rdata;
    end
  end
  assign sram_a_o    = mem_addr;
  assign axi.awready = aw_rdy;
  assign axi.arready = ar_rdy;
  assign axi.wready  = state_q == WR_DATA;
  assign axi.rvalid  = state_q == RD_DATA;
  assign axi.rlast   = (state_q == RD_DATA) & last;
  assign axi.rdata   = rdata;
  assign axi.rid     = id_q;
  assign axi.rresp   = RESP_OKAY;
  assign axi.bvalid  = state_q == WR_RESP;
  assign axi.bid     = id_q;
  assign axi.bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
endmodule
